// File: rtl/alu_issue_stage.sv
// RV32I ALU issue stage: decodes R/I-type ALU ops, tracks register busy bits,
// reads a 32x32 register file with writeback bypass and issues one op per cycle.
module alu_issue_stage #(
  parameter int BYPASS_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] operand_a,
  output logic [31:0] operand_b,
  output logic [3:0]  alu_opcode,
  output logic [4:0]  rd,
  output logic        illegal_pulse,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data
);

  localparam int DATA_W = 32;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  localparam logic [6:0] OPC_REG = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  function automatic logic signed [DATA_W-1:0] sext_imm12(input logic signed [11:0] imm);
    return {{(DATA_W-12){imm[11]}}, imm};
  endfunction

  function automatic logic [DATA_W-1:0] zext_shamt(input logic [4:0] shamt);
    return {{(DATA_W-5){1'b0}}, shamt};
  endfunction

  logic [DATA_W-1:0] rf [32];
  logic [31:0]       busy;
  logic [31:0]       busy_nxt;

  logic [6:0]        opc_p0;
  logic [4:0]        rd_p0;
  logic [2:0]        f3_p0;
  logic [4:0]        rs1_p0;
  logic [4:0]        rs2_p0;
  logic [6:0]        f7_p0;
  logic              legal_p0;
  logic              is_r_p0;
  logic              is_shift_p0;
  logic [3:0]        op_p0;
  logic [DATA_W-1:0] imm_p0;
  logic              byp1_p0;
  logic              byp2_p0;
  logic              hazard_p0;
  logic [DATA_W-1:0] src_a_p0;
  logic [DATA_W-1:0] src_b_p0;
  logic              accept_p0;

  logic              vld_p1;
  logic              illegal_p1;
  logic [DATA_W-1:0] a_p1;
  logic [DATA_W-1:0] b_p1;
  logic [3:0]        op_p1;
  logic [4:0]        rd_p1;

  assign opc_p0 = instr[6:0];
  assign rd_p0  = instr[11:7];
  assign f3_p0  = instr[14:12];
  assign rs1_p0 = instr[19:15];
  assign rs2_p0 = instr[24:20];
  assign f7_p0  = instr[31:25];

  always_comb begin
    legal_p0    = 1'b0;
    is_r_p0     = 1'b0;
    is_shift_p0 = 1'b0;
    op_p0       = OP_ADD;
    if (opc_p0 == OPC_REG) begin
      is_r_p0 = 1'b1;
      unique case (f3_p0)
        3'b000: begin
          legal_p0 = (f7_p0 == F7_BASE) || (f7_p0 == F7_ALT);
          op_p0    = (f7_p0 == F7_ALT) ? OP_SUB : OP_ADD;
        end
        3'b001: begin legal_p0 = (f7_p0 == F7_BASE); op_p0 = OP_SLL;  end
        3'b010: begin legal_p0 = (f7_p0 == F7_BASE); op_p0 = OP_SLT;  end
        3'b011: begin legal_p0 = (f7_p0 == F7_BASE); op_p0 = OP_SLTU; end
        3'b100: begin legal_p0 = (f7_p0 == F7_BASE); op_p0 = OP_XOR;  end
        3'b101: begin
          legal_p0 = (f7_p0 == F7_BASE) || (f7_p0 == F7_ALT);
          op_p0    = (f7_p0 == F7_ALT) ? OP_SRA : OP_SRL;
        end
        3'b110: begin legal_p0 = (f7_p0 == F7_BASE); op_p0 = OP_OR;   end
        default: begin legal_p0 = (f7_p0 == F7_BASE); op_p0 = OP_AND; end
      endcase
    end else if (opc_p0 == OPC_IMM) begin
      unique case (f3_p0)
        3'b000: begin legal_p0 = 1'b1; op_p0 = OP_ADD;  end
        3'b001: begin
          legal_p0    = (f7_p0 == F7_BASE);
          is_shift_p0 = 1'b1;
          op_p0       = OP_SLL;
        end
        3'b010: begin legal_p0 = 1'b1; op_p0 = OP_SLT;  end
        3'b011: begin legal_p0 = 1'b1; op_p0 = OP_SLTU; end
        3'b100: begin legal_p0 = 1'b1; op_p0 = OP_XOR;  end
        3'b101: begin
          legal_p0    = (f7_p0 == F7_BASE) || (f7_p0 == F7_ALT);
          is_shift_p0 = 1'b1;
          op_p0       = (f7_p0 == F7_ALT) ? OP_SRA : OP_SRL;
        end
        3'b110: begin legal_p0 = 1'b1; op_p0 = OP_OR;   end
        default: begin legal_p0 = 1'b1; op_p0 = OP_AND; end
      endcase
    end
  end

  // Shift immediates carry funct7 in [31:25]; only the shamt reaches the ALU.
  assign imm_p0 = is_shift_p0 ? zext_shamt(rs2_p0) : sext_imm12(instr[31:20]);

  assign byp1_p0 = (BYPASS_EN != 0) && wb_valid && (wb_rd == rs1_p0) &&
                   (rs1_p0 != 5'd0) && busy[rs1_p0];
  assign byp2_p0 = (BYPASS_EN != 0) && wb_valid && (wb_rd == rs2_p0) &&
                   (rs2_p0 != 5'd0) && busy[rs2_p0];

  assign hazard_p0 = (busy[rs1_p0] && !byp1_p0) ||
                     (is_r_p0 && busy[rs2_p0] && !byp2_p0) ||
                     ((rd_p0 != 5'd0) && busy[rd_p0]);

  always_comb begin
    src_a_p0 = (rs1_p0 == 5'd0) ? '0 : rf[rs1_p0];
    if (byp1_p0) src_a_p0 = wb_data;
    src_b_p0 = imm_p0;
    if (is_r_p0) begin
      src_b_p0 = (rs2_p0 == 5'd0) ? '0 : rf[rs2_p0];
      if (byp2_p0) src_b_p0 = wb_data;
    end
  end

  assign instr_ready = !rst && (!vld_p1 || out_ready) && !(legal_p0 && hazard_p0);
  assign accept_p0   = instr_valid && instr_ready;

  // Set beats clear when an accepted rd coincides with a writeback to it.
  always_comb begin
    busy_nxt = busy;
    if (wb_valid) busy_nxt[wb_rd] = 1'b0;
    if (accept_p0 && legal_p0 && (rd_p0 != 5'd0)) busy_nxt[rd_p0] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Issue register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      illegal_p1 <= 1'b0;
      busy       <= '0;
      a_p1       <= '0;
      b_p1       <= '0;
      op_p1      <= OP_ADD;
      rd_p1      <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      if (wb_valid && (wb_rd != 5'd0)) rf[wb_rd] <= wb_data;
      busy       <= busy_nxt;
      illegal_p1 <= accept_p0 && !legal_p0;
      if (accept_p0 && legal_p0) begin
        vld_p1 <= 1'b1;
        a_p1   <= src_a_p0;
        b_p1   <= src_b_p0;
        op_p1  <= op_p0;
        rd_p1  <= rd_p0;
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid     = vld_p1;
  assign illegal_pulse = illegal_p1;
  assign operand_a     = a_p1;
  assign operand_b     = b_p1;
  assign alu_opcode    = op_p1;
  assign rd            = rd_p1;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: a decode/operand vector table issued
// back-to-back plus hand-written hazard, stall, illegal and reset sequences.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [3:0]  alu_opcode;
  logic [4:0]  rd;
  logic        illegal_pulse;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int tests;
  int fails;

  alu_issue_stage #(.BYPASS_EN(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .alu_opcode   (alu_opcode),
    .rd           (rd),
    .illegal_pulse(illegal_pulse),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        legal;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } vec_t;

  vec_t vecs [24];

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rdi);
    return {f7, rs2, rs1, f3, rdi, 7'b0110011};
  endfunction

  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rdi);
    return {imm, rs1, f3, rdi, 7'b0010011};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    wb_valid = 1'b1;
    wb_rd    = r;
    wb_data  = d;
    tick();
    wb_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = 32'h0;
    out_ready = 1'b1;
    wb_valid = 1'b0;
    wb_rd = 5'd0;
    wb_data = 32'h0;

    vecs[0]  = '{32'h002081B3,                         1'b1, 4'd0, 32'd5,         32'd3,         5'd3};
    vecs[1]  = '{rtype(7'h20, 5'd2, 5'd1, 3'd0, 5'd8),  1'b1, 4'd1, 32'd5,         32'd3,         5'd8};
    vecs[2]  = '{rtype(7'h00, 5'd1, 5'd2, 3'd1, 5'd9),  1'b1, 4'd2, 32'd3,         32'd5,         5'd9};
    vecs[3]  = '{rtype(7'h00, 5'd1, 5'd7, 3'd2, 5'd10), 1'b1, 4'd3, 32'h80000000,  32'd5,         5'd10};
    vecs[4]  = '{rtype(7'h00, 5'd7, 5'd1, 3'd3, 5'd11), 1'b1, 4'd4, 32'd5,         32'h80000000,  5'd11};
    vecs[5]  = '{rtype(7'h00, 5'd2, 5'd2, 3'd4, 5'd12), 1'b1, 4'd5, 32'd3,         32'd3,         5'd12};
    vecs[6]  = '{rtype(7'h00, 5'd2, 5'd7, 3'd5, 5'd13), 1'b1, 4'd6, 32'h80000000,  32'd3,         5'd13};
    vecs[7]  = '{rtype(7'h20, 5'd1, 5'd7, 3'd5, 5'd14), 1'b1, 4'd7, 32'h80000000,  32'd5,         5'd14};
    vecs[8]  = '{rtype(7'h00, 5'd1, 5'd0, 3'd6, 5'd15), 1'b1, 4'd8, 32'd0,         32'd5,         5'd15};
    vecs[9]  = '{rtype(7'h00, 5'd0, 5'd1, 3'd7, 5'd16), 1'b1, 4'd9, 32'd5,         32'd0,         5'd16};
    vecs[10] = '{itype(12'hFFD, 5'd1, 3'd0, 5'd17),     1'b1, 4'd0, 32'd5,         32'hFFFFFFFD,  5'd17};
    vecs[11] = '{itype(12'h7FF, 5'd1, 3'd2, 5'd18),     1'b1, 4'd3, 32'd5,         32'h000007FF,  5'd18};
    vecs[12] = '{itype(12'hFFF, 5'd2, 3'd3, 5'd19),     1'b1, 4'd4, 32'd3,         32'hFFFFFFFF,  5'd19};
    vecs[13] = '{itype(12'h123, 5'd0, 3'd4, 5'd20),     1'b1, 4'd5, 32'd0,         32'h00000123,  5'd20};
    vecs[14] = '{itype(12'h800, 5'd7, 3'd6, 5'd21),     1'b1, 4'd8, 32'h80000000,  32'hFFFFF800,  5'd21};
    vecs[15] = '{itype(12'h0F0, 5'd2, 3'd7, 5'd22),     1'b1, 4'd9, 32'd3,         32'h000000F0,  5'd22};
    vecs[16] = '{itype({7'h00, 5'd31}, 5'd1, 3'd1, 5'd23), 1'b1, 4'd2, 32'd5,      32'd31,        5'd23};
    vecs[17] = '{itype({7'h00, 5'd1}, 5'd2, 3'd5, 5'd24),  1'b1, 4'd6, 32'd3,      32'd1,         5'd24};
    vecs[18] = '{itype({7'h20, 5'd3}, 5'd7, 3'd5, 5'd25),  1'b1, 4'd7, 32'h80000000, 32'd3,       5'd25};
    vecs[19] = '{rtype(7'h20, 5'd2, 5'd1, 3'd1, 5'd26), 1'b0, 4'd0, 32'd0, 32'd0, 5'd0};
    vecs[20] = '{rtype(7'h01, 5'd2, 5'd1, 3'd0, 5'd26), 1'b0, 4'd0, 32'd0, 32'd0, 5'd0};
    vecs[21] = '{itype({7'h20, 5'd1}, 5'd1, 3'd1, 5'd26),  1'b0, 4'd0, 32'd0, 32'd0, 5'd0};
    vecs[22] = '{itype({7'h01, 5'd1}, 5'd1, 3'd5, 5'd26),  1'b0, 4'd0, 32'd0, 32'd0, 5'd0};
    vecs[23] = '{{12'h000, 5'd1, 3'b010, 5'd26, 7'b0000011}, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0};

    // Reset state, with a pending instruction presented
    instr_valid = 1'b1;
    instr = 32'h002081B3;
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_illegal", 32'(illegal_pulse), 32'd0);
    chk("rst_operand_a", operand_a, 32'd0);
    chk("rst_operand_b", operand_b, 32'd0);
    chk("rst_opcode", 32'(alu_opcode), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_instr_ready", 32'(instr_ready), 32'd0);
    instr_valid = 1'b0;
    rst = 1'b0;

    wb_write(5'd1, 32'd5);
    wb_write(5'd2, 32'd3);
    wb_write(5'd7, 32'h80000000);
    wb_write(5'd0, 32'd123);

    // Back-to-back table issue
    for (int i = 0; i < 24; i++) begin
      instr = vecs[i].instr;
      instr_valid = 1'b1;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(instr_ready), 32'd1);
      tick();
      instr_valid = 1'b0;
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].legal));
      chk($sformatf("v%0d_illegal", i), 32'(illegal_pulse), 32'(!vecs[i].legal));
      if (vecs[i].legal) begin
        chk($sformatf("v%0d_opcode", i), 32'(alu_opcode), 32'(vecs[i].op));
        chk($sformatf("v%0d_operand_a", i), operand_a, vecs[i].a);
        chk($sformatf("v%0d_operand_b", i), operand_b, vecs[i].b);
        chk($sformatf("v%0d_rd", i), 32'(rd), 32'(vecs[i].rd));
      end
    end

    // addi x4,x0,-1 then srai x5,x4,4 stalls until the x4 writeback bypasses
    instr = 32'hFFF00213;
    instr_valid = 1'b1;
    #1;
    chk("addi_ready", 32'(instr_ready), 32'd1);
    tick();
    chk("addi_out_valid", 32'(out_valid), 32'd1);
    chk("addi_operand_a", operand_a, 32'd0);
    chk("addi_operand_b", operand_b, 32'hFFFFFFFF);
    chk("addi_opcode", 32'(alu_opcode), 32'd0);
    instr = itype({7'h20, 5'd4}, 5'd4, 3'd5, 5'd5);
    #1;
    chk("srai_stall0", 32'(instr_ready), 32'd0);
    tick();
    chk("srai_stall_out_valid", 32'(out_valid), 32'd0);
    chk("srai_stall1", 32'(instr_ready), 32'd0);
    wb_valid = 1'b1;
    wb_rd = 5'd4;
    wb_data = 32'hFFFFFFFF;
    #1;
    chk("srai_bypass_ready", 32'(instr_ready), 32'd1);
    tick();
    wb_valid = 1'b0;
    instr_valid = 1'b0;
    chk("srai_out_valid", 32'(out_valid), 32'd1);
    chk("srai_operand_a", operand_a, 32'hFFFFFFFF);
    chk("srai_operand_b", operand_b, 32'd4);
    chk("srai_opcode", 32'(alu_opcode), 32'd7);
    chk("srai_rd", 32'(rd), 32'd5);

    // Set wins over a same-cycle clear of the same busy bit
    instr = rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd6);
    instr_valid = 1'b1;
    wb_valid = 1'b1;
    wb_rd = 5'd6;
    wb_data = 32'd9;
    #1;
    chk("setwin_ready", 32'(instr_ready), 32'd1);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("setwin_waw_stall", 32'(instr_ready), 32'd0);
    instr_valid = 1'b0;

    // Downstream stall for 3 cycles, then back-to-back issue
    instr = rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd26);
    instr_valid = 1'b1;
    #1;
    chk("stall_first_ready", 32'(instr_ready), 32'd1);
    tick();
    chk("stall_first_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    instr = rtype(7'h00, 5'd2, 5'd1, 3'd4, 5'd27);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d_ready", c), 32'(instr_ready), 32'd0);
      tick();
      chk($sformatf("stall%0d_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("stall%0d_rd", c), 32'(rd), 32'd26);
      chk($sformatf("stall%0d_opcode", c), 32'(alu_opcode), 32'd0);
      chk($sformatf("stall%0d_operand_a", c), operand_a, 32'd5);
      chk($sformatf("stall%0d_operand_b", c), operand_b, 32'd3);
    end
    out_ready = 1'b1;
    #1;
    chk("b2b_ready", 32'(instr_ready), 32'd1);
    tick();
    chk("b2b_valid", 32'(out_valid), 32'd1);
    chk("b2b_rd", 32'(rd), 32'd27);
    chk("b2b_opcode", 32'(alu_opcode), 32'd5);

    // ecall and a hazarded load are consumed as illegal with no state change
    instr = 32'h00000073;
    #1;
    chk("ecall_ready", 32'(instr_ready), 32'd1);
    tick();
    instr_valid = 1'b0;
    chk("ecall_out_valid", 32'(out_valid), 32'd0);
    chk("ecall_illegal", 32'(illegal_pulse), 32'd1);
    tick();
    chk("ecall_illegal_drop", 32'(illegal_pulse), 32'd0);
    instr = {12'h000, 5'd26, 3'b010, 5'd29, 7'b0000011};
    instr_valid = 1'b1;
    #1;
    chk("lw_ignores_hazard", 32'(instr_ready), 32'd1);
    tick();
    chk("lw_illegal", 32'(illegal_pulse), 32'd1);
    chk("lw_out_valid", 32'(out_valid), 32'd0);
    instr = rtype(7'h00, 5'd1, 5'd26, 3'd0, 5'd29);
    #1;
    chk("busy26_kept", 32'(instr_ready), 32'd0);
    instr = rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd29);
    #1;
    chk("rd29_not_busy", 32'(instr_ready), 32'd1);
    tick();
    chk("add29_valid", 32'(out_valid), 32'd1);
    chk("add29_rd", 32'(rd), 32'd29);

    // Reset while an issue is pending and x3 is busy; writeback ignored
    instr_valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    wb_valid = 1'b1;
    wb_rd = 5'd9;
    wb_data = 32'd77;
    #1;
    chk("midrst_ready", 32'(instr_ready), 32'd0);
    tick();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_illegal", 32'(illegal_pulse), 32'd0);
    chk("midrst_rd", 32'(rd), 32'd0);
    chk("midrst_operand_a", operand_a, 32'd0);
    rst = 1'b0;
    wb_valid = 1'b0;
    out_ready = 1'b1;
    instr = rtype(7'h00, 5'd1, 5'd9, 3'd0, 5'd3);
    instr_valid = 1'b1;
    #1;
    chk("postrst_x3_free", 32'(instr_ready), 32'd1);
    tick();
    instr_valid = 1'b0;
    chk("postrst_valid", 32'(out_valid), 32'd1);
    chk("postrst_x9_zero", operand_a, 32'd0);
    chk("postrst_x1_zero", operand_b, 32'd0);
    chk("postrst_rd", 32'(rd), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter BYPASS_EN, default 1, meaning: 1 = same-cycle writeback-to-issue operand bypass enabled; 0 = disabled, so the source stalls until its busy bit clears.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 instr_valid  input  1  upstream instruction valid.
REQ-005 instr_ready  output  1  stage accepts instr this cycle.
REQ-006 instr  input  32  RV32I instruction word.
REQ-007 out_valid  output  1  issued ALU operation valid.
REQ-008 out_ready  input  1  downstream ALU/writeback accepts issue.
REQ-009 operand_a  output  32  rs1 value.
REQ-010 operand_b  output  32  rs2 value or immediate.
REQ-011 alu_opcode  output  4  ALU op code.
REQ-012 rd  output  5  destination register.
REQ-013 illegal_pulse  output  1  one-cycle flag: non-ALU or unsupported encoding was consumed.
REQ-014 wb_valid  input  1  writeback strobe.
REQ-015 wb_rd  input  5  writeback register index.
REQ-016 wb_data  input  32  writeback value.

Function
REQ-017 alu_opcode SHALL use ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
REQ-018 R-type (opcode 0110011) SHALL decode funct3/funct7: 000/0000000 ADD, 000/0100000 SUB, 001/0000000 SLL, 010/0000000 SLT, 011/0000000 SLTU, 100/0000000 XOR, 101/0000000 SRL, 101/0100000 SRA, 110/0000000 OR, 111/0000000 AND; operand_b = rs2 value.
REQ-019 I-type (opcode 0010011) SHALL decode funct3 as in REQ-018 without SUB; operand_b = sign-extended instr[31:20]; for funct3 001/101, instr[31:25] SHALL be 0000000 (SLLI/SRLI) or 0100000 (SRAI, funct3 101 only), operand_b = {27'b0, instr[24:20]}.
REQ-020 Any other encoding SHALL be illegal: consumed without issue, illegal_pulse=1 in the following cycle, no state change.
REQ-021 Internal 32x32 register file; reads of x0 SHALL return 0; wb_valid with wb_rd=0 SHALL be ignored; otherwise write wb_data at the clock edge.
REQ-022 Scoreboard: 32 busy bits; accepting a legal instr with rd!=0 SHALL set busy[rd]; wb_valid SHALL clear busy[wb_rd]; set and clear to same index in one cycle: set wins.
REQ-023 Hazard SHALL exist if rs1 busy, rs2 busy (R-type only), or rd busy (WAW); with BYPASS_EN=1 a busy source matching wb_rd under wb_valid is not a hazard and SHALL use wb_data.
REQ-024 instr_ready = (!out_valid || out_ready) && !(legal && hazard); illegal encodings ignore the hazard.
REQ-025 Handshake fires on instr_valid && instr_ready; output register loads at that edge; out_valid rises next cycle (latency 1).
REQ-026 While out_valid && !out_ready, operand_a, operand_b, alu_opcode, rd SHALL hold stable.
REQ-027 out_valid SHALL clear after out_valid && out_ready unless a new instr is accepted in the same cycle (back-to-back, 1 issue/cycle).
REQ-028 Register-file reads use pre-edge contents; a same-cycle writeback reaches operands only via REQ-023 bypass.
REQ-029 Immediate and shift arithmetic are 32-bit; no exceptions other than illegal_pulse.

Reset
REQ-030 With rst=1 at an edge: out_valid=0, illegal_pulse=0, all busy bits=0, all registers=0, operand_a/operand_b/rd=0, alu_opcode=0; instr_ready=0 during reset.
REQ-031 Reset mid-operation SHALL discard any pending issue; wb_valid in a reset cycle SHALL be ignored.

Verification
REQ-032 wb x1=5, x2=3; issue 0x002081B3 (add x3,x1,x2) -> next cycle out_valid=1, operand_a=5, operand_b=3, alu_opcode=0, rd=3.
REQ-033 addi x4,x0,-1 (0xFFF00213) -> operand_a=0, operand_b=0xFFFFFFFF, alu_opcode=0; srai x5,x4,4 -> instr_ready=0 until wb x4 (bypass: same cycle, operand_a=wb_data, operand_b=4, alu_opcode=7).
REQ-034 out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, instr_ready=0; out_ready=1 with new instr -> back-to-back issue, no bubble.
REQ-035 instr=0x00000073 (ecall) -> no out_valid, illegal_pulse=1 for one cycle, busy bits unchanged.
REQ-036 Assert rst while out_valid=1 and busy[3]=1 -> next cycle out_valid=0, busy cleared, x1 reads 0.
